// File: rtl/ff_bank_multimode.sv
// Bank of WIDTH flip-flops with a run-time selectable D / T / SR / JK update rule,
// a sticky record of illegal SR inputs and a registered "something changed" pulse.
module ff_bank_multimode #(
    parameter int unsigned       WIDTH     = 8,
    parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             clr_err,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_bar,
    output logic             changed,
    output logic             illegal,
    output logic [WIDTH-1:0] illegal_bits
);

    localparam logic [1:0] MODE_D  = 2'b00;
    localparam logic [1:0] MODE_T  = 2'b01;
    localparam logic [1:0] MODE_SR = 2'b10;
    localparam logic [1:0] MODE_JK = 2'b11;

    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] illegal_evt;
    logic [WIDTH-1:0] illegal_bits_next;

    // SR with S=R=1 keeps q: set only where a&~b, reset only where b&~a.
    always_comb begin
        q_next = q;
        if (en) begin
            case (mode)
                MODE_D:  q_next = a;
                MODE_T:  q_next = q ^ a;
                MODE_SR: q_next = (q | (a & ~b)) & ~(b & ~a);
                MODE_JK: q_next = (a & ~q) | (~b & q);
                default: q_next = q;
            endcase
        end
    end

    always_comb begin
        illegal_evt = '0;
        if (en && mode == MODE_SR) begin
            illegal_evt = a & b;
        end
        // A new event on the clearing edge wins over the clear.
        if (clr_err) begin
            illegal_bits_next = illegal_evt;
        end else begin
            illegal_bits_next = illegal_bits | illegal_evt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q            <= RESET_VAL;
            changed      <= 1'b0;
            illegal_bits <= '0;
        end else begin
            q            <= q_next;
            changed      <= en & (q_next != q);
            illegal_bits <= illegal_bits_next;
        end
    end

    assign q_bar   = ~q;
    assign illegal = |illegal_bits;

endmodule
